dmi_req_buffer: RTL and testbench

- Core-clock buffering and supervision stage between the JTAG DTM core-side DMI port (upstream) and the debug module CSR block (downstream).
- Decouples the two sides with a request FIFO and a response FIFO.
- Allows one outstanding DMI transaction toward the debug module.
- Watchdog turns a missing debug-module response into a DTM_ERR response, so the DTM FSM can never hang.

---
 rtl/dmi_req_buffer_pkg.sv | 36 +++
 rtl/dmi_req_buffer_if.sv | 28 ++
 rtl/dmi_req_buffer_fifo.sv | 55 +++++
 rtl/dmi_req_buffer.sv | 131 +++++++++++++
 tb/tb_dmi_req_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmi_req_buffer_pkg.sv
// rtl/dmi_req_buffer_pkg.sv - DMI request/response types and buffer FSM states
package dmi_req_buffer_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DTM_SUCCESS = 2'h0,
    DTM_ERR     = 2'h2,
    DTM_BUSY    = 2'h3
  } dtm_resp_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    dtm_resp_e   resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Issue = 2'd1,
    Wait  = 2'd2
  } dmi_buf_state_e;

  localparam dmi_resp_t DmiTimeoutResp = '{data: '0, resp: DTM_ERR};
  localparam logic [1:0] DropMax = 2'd3;

endpackage

// File: rtl/dmi_req_buffer_if.sv
// rtl/dmi_req_buffer_if.sv - upstream (DTM) and downstream (debug module) DMI handshake bundle
interface dmi_req_buffer_if;
  import dmi_req_buffer_pkg::*;

  dmi_req_t  up_req_i;
  logic      up_req_valid_i;
  logic      up_req_ready_o;
  dmi_resp_t up_resp_o;
  logic      up_resp_valid_o;
  logic      up_resp_ready_i;
  dmi_req_t  dn_req_o;
  logic      dn_req_valid_o;
  logic      dn_req_ready_i;
  dmi_resp_t dn_resp_i;
  logic      dn_resp_valid_i;
  logic      dn_resp_ready_o;

  modport slave (
    input  up_req_i, up_req_valid_i, up_resp_ready_i, dn_req_ready_i, dn_resp_i, dn_resp_valid_i,
    output up_req_ready_o, up_resp_o, up_resp_valid_o, dn_req_o, dn_req_valid_o, dn_resp_ready_o
  );

  modport master (
    output up_req_i, up_req_valid_i, up_resp_ready_i, dn_req_ready_i, dn_resp_i, dn_resp_valid_i,
    input  up_req_ready_o, up_resp_o, up_resp_valid_o, dn_req_o, dn_req_valid_o, dn_resp_ready_o
  );

endinterface

// File: rtl/dmi_req_buffer_fifo.sv
// rtl/dmi_req_buffer_fifo.sv - registered FIFO with flush; push while full is legal only with a pop
module dmi_req_buffer_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T               mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/dmi_req_buffer.sv
// rtl/dmi_req_buffer.sv - DMI request/response buffering with one outstanding transaction and a response watchdog
module dmi_req_buffer
  import dmi_req_buffer_pkg::*;
#(
  parameter int unsigned ReqDepth      = 2,
  parameter int unsigned RespDepth     = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  dmi_req_buffer_if.slave   bus,
  output logic              timeout_o,
  output logic              busy_o
);

  if ((TimeoutCycles >> CntWidth) != 0) begin : g_timeout_width_check
    $error("TimeoutCycles does not fit in CntWidth bits");
  end

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  dmi_buf_state_e      state_q, state_d;
  logic [CntWidth-1:0] wdog_q, wdog_d;
  logic [1:0]          drop_cnt_q, drop_cnt_d;
  logic                req_full, req_empty, req_pop;
  logic                rsp_full, rsp_empty, rsp_push;
  dmi_resp_t           rsp_wdata;
  logic                can_issue, late_resp;

  assign bus.up_req_ready_o  = !req_full;
  assign bus.up_resp_valid_o = !rsp_empty;
  assign bus.dn_resp_ready_o = 1'b1;
  assign busy_o              = (state_q != Idle) || !req_empty;

  dmi_req_buffer_fifo #(.Depth(ReqDepth), .T(dmi_req_t)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (bus.up_req_valid_i && bus.up_req_ready_o),
    .data_i  (bus.up_req_i),
    .pop_i   (req_pop),
    .data_o  (bus.dn_req_o),
    .full_o  (req_full),
    .empty_o (req_empty)
  );

  dmi_req_buffer_fifo #(.Depth(RespDepth), .T(dmi_resp_t)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (rsp_push),
    .data_i  (rsp_wdata),
    .pop_i   (bus.up_resp_valid_o && bus.up_resp_ready_i),
    .data_o  (bus.up_resp_o),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  // A free response slot is the reservation for the transaction about to be issued.
  assign can_issue = !req_empty && !rsp_full;
  assign late_resp = bus.dn_resp_valid_i && (drop_cnt_q != 2'd0);

  always_comb begin
    state_d            = state_q;
    wdog_d             = wdog_q;
    drop_cnt_d         = drop_cnt_q;
    req_pop            = 1'b0;
    rsp_push           = 1'b0;
    rsp_wdata          = bus.dn_resp_i;
    timeout_o          = 1'b0;
    bus.dn_req_valid_o = 1'b0;

    case (state_q)
      // Idle presents the head request at once so the FIFO register is the only latency stage.
      Idle, Issue: begin
        if (late_resp) drop_cnt_d = drop_cnt_q - 2'd1;
        if (state_q == Issue || can_issue) begin
          bus.dn_req_valid_o = 1'b1;
          if (bus.dn_req_ready_i) begin
            req_pop = 1'b1;
            wdog_d  = '0;
            state_d = Wait;
          end else begin
            state_d = Issue;
          end
        end
      end
      Wait: begin
        wdog_d = wdog_q + CntWidth'(1);
        if (bus.dn_resp_valid_i) begin
          rsp_push = 1'b1;
          state_d  = Idle;
        end else if (TimeoutCycles != 0 && wdog_q == TimeoutLast) begin
          rsp_push  = 1'b1;
          rsp_wdata = DmiTimeoutResp;
          timeout_o = 1'b1;
          if (drop_cnt_q != DropMax) drop_cnt_d = drop_cnt_q + 2'd1;
          state_d   = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    if (clear_i) begin
      state_d    = Idle;
      wdog_d     = '0;
      req_pop    = 1'b0;
      rsp_push   = 1'b0;
      timeout_o  = 1'b0;
      drop_cnt_d = drop_cnt_q;
      // The debug module still owes the response of an abandoned Wait.
      if (state_q == Wait && drop_cnt_q != DropMax) drop_cnt_d = drop_cnt_q + 2'd1;
      if (state_q == Idle) bus.dn_req_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      wdog_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmi_req_buffer.sv
// tb/tb_dmi_req_buffer.sv - scoreboard bench for dmi_req_buffer with a behavioural debug module
module tb_dmi_req_buffer;
  import dmi_req_buffer_pkg::*;

  localparam int unsigned Tmo = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic timeout, busy;

  always #5 clk = ~clk;

  dmi_req_buffer_if bus ();

  dmi_req_buffer #(
    .ReqDepth(2), .RespDepth(2), .TimeoutCycles(Tmo), .CntWidth(16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .bus       (bus),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_issued = 0;
  int n_rsp = 0;
  int n_exp = 0;
  int hs_cyc = 0;
  int to_cyc = 0;
  int to_count = 0;
  int dm_lat = 3;
  bit dm_silent = 1'b0;
  bit dm_drove = 1'b0;
  logic [31:0] dm_mem [128];
  dmi_req_t  dm_req;
  dmi_resp_t exp_q [$];
  dmi_resp_t exp_e;
  dmi_req_t  prev_req;
  logic      prev_vld = 1'b0;
  logic      prev_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural debug module: answers each accepted request dm_lat cycles after the handshake.
  always begin
    @(negedge clk);
    #1;
    if (dm_drove) begin
      bus.dn_resp_valid_i = 1'b0;
      dm_drove = 1'b0;
    end
    if (rst_n && !clear && bus.dn_req_valid_o && bus.dn_req_ready_i) begin
      dm_req = bus.dn_req_o;
      n_issued++;
      hs_cyc = cyc;
      if (dm_req.op == DTM_WRITE) dm_mem[dm_req.addr] = dm_req.data;
      if (!dm_silent) begin
        repeat (dm_lat) @(negedge clk);
        #1;
        bus.dn_resp_i.data = (dm_req.op == DTM_WRITE) ? 32'h0 : dm_mem[dm_req.addr];
        bus.dn_resp_i.resp = DTM_SUCCESS;
        bus.dn_resp_valid_i = 1'b1;
        dm_drove = 1'b1;
      end
    end
  end

  // Upstream monitor: scoreboard compare on each response handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && timeout) begin
      to_cyc = cyc;
      to_count++;
    end
    if (rst_n && !clear && bus.up_resp_valid_o && bus.up_resp_ready_i) begin
      n_rsp++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected: got data=%h resp=%0d, required no response", bus.up_resp_o.data, bus.up_resp_o.resp);
      end else begin
        exp_e = exp_q.pop_front();
        if (bus.up_resp_o !== exp_e)
          $display("FAIL resp_data: got data=%h resp=%0d, required data=%h resp=%0d",
                   bus.up_resp_o.data, bus.up_resp_o.resp, exp_e.data, exp_e.resp);
        else n_pass++;
      end
    end
    if (rst_n && prev_vld && !prev_rdy)
      assert (bus.up_req_valid_i && bus.up_req_i == prev_req) else $error("upstream valid dropped before accept");
    if (rst_n && dut.drop_cnt_q == 2'd0)
      assert (!(bus.dn_resp_valid_i && bus.dn_req_valid_o)) else $error("debug module answered an unissued request");
    prev_vld = bus.up_req_valid_i;
    prev_rdy = bus.up_req_ready_o;
    prev_req = bus.up_req_i;
  end

  task automatic send(input logic [6:0] a, input dtm_op_e o, input logic [31:0] d,
                      input bit expect_it, input dmi_resp_t e);
    @(negedge clk);
    bus.up_req_i = '{addr: a, op: o, data: d};
    bus.up_req_valid_i = 1'b1;
    if (expect_it) begin
      exp_q.push_back(e);
      n_exp++;
    end
    #1;
    for (int i = 0; i < 100 && !bus.up_req_ready_o; i++) begin
      @(negedge clk);
      #1;
    end
    if (!bus.up_req_ready_o) begin
      n_checks++;
      $display("FAIL send_accept: up_req_ready_o=%b, required 1 within 100 cycles", bus.up_req_ready_o);
    end
    @(negedge clk);
    bus.up_req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #3;
    n_checks += 8;
    if (bus.up_req_ready_o !== 1'b1) $display("FAIL reset_up_req_ready: got %b, required 1", bus.up_req_ready_o); else n_pass++;
    if (bus.dn_resp_ready_o !== 1'b1) $display("FAIL reset_dn_resp_ready: got %b, required 1", bus.dn_resp_ready_o); else n_pass++;
    if (bus.up_resp_valid_o !== 1'b0) $display("FAIL reset_up_resp_valid: got %b, required 0", bus.up_resp_valid_o); else n_pass++;
    if (bus.dn_req_valid_o !== 1'b0) $display("FAIL reset_dn_req_valid: got %b, required 0", bus.dn_req_valid_o); else n_pass++;
    if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b, required 0", timeout); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    if (bus.up_resp_o !== '0) $display("FAIL reset_up_resp: got %h, required 0", bus.up_resp_o); else n_pass++;
    if (bus.dn_req_o !== '0) $display("FAIL reset_dn_req: got %h, required 0", bus.dn_req_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    dmi_req_t wr;
    wr = '{addr: 7'h10, op: DTM_WRITE, data: 32'hDEADBEEF};
    dm_lat = 3;
    @(negedge clk);
    bus.up_req_i = wr;
    bus.up_req_valid_i = 1'b1;
    exp_q.push_back('{data: 32'h0, resp: DTM_SUCCESS});
    n_exp++;
    #3;
    n_checks += 2;
    if (bus.up_req_ready_o !== 1'b1) $display("FAIL basic_accept: up_req_ready_o=%b, required 1", bus.up_req_ready_o); else n_pass++;
    if (bus.dn_req_valid_o !== 1'b0) $display("FAIL basic_no_fallthrough: dn_req_valid_o=%b, required 0", bus.dn_req_valid_o); else n_pass++;
    @(negedge clk);
    bus.up_req_valid_i = 1'b0;
    #2;
    n_checks += 2;
    if (bus.dn_req_valid_o !== 1'b1) $display("FAIL basic_latency: dn_req_valid_o=%b, required 1", bus.dn_req_valid_o); else n_pass++;
    if (bus.dn_req_o !== wr) $display("FAIL basic_dn_req: got %h, required %h", bus.dn_req_o, wr); else n_pass++;
    send(7'h11, DTM_READ, 32'h0, 1'b1, '{data: 32'h12345678, resp: DTM_SUCCESS});
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks += 2;
    if (exp_q.size() != 0) $display("FAIL basic_drain: %0d outstanding, required 0", exp_q.size()); else n_pass++;
    if (dm_mem[7'h10] !== 32'hDEADBEEF) $display("FAIL basic_write_data: got %h, required deadbeef", dm_mem[7'h10]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = n_issued;
    dm_lat = 1;
    bus.up_resp_ready_i = 1'b0;
    for (int k = 0; k < 4; k++)
      send(7'h20 + 7'(k), DTM_READ, 32'h0, 1'b1, '{data: 32'hA000_0000 + 32'(k), resp: DTM_SUCCESS});
    repeat (10) @(negedge clk);
    #3;
    n_checks += 3;
    if (n_issued - n0 != 2) $display("FAIL bp_issues: got %0d, required 2", n_issued - n0); else n_pass++;
    if (bus.up_req_ready_o !== 1'b0) $display("FAIL bp_req_ready: got %b, required 0", bus.up_req_ready_o); else n_pass++;
    if (bus.up_resp_valid_o !== 1'b1) $display("FAIL bp_resp_valid: got %b, required 1", bus.up_resp_valid_o); else n_pass++;
    @(negedge clk);
    bus.up_resp_ready_i = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks += 2;
    if (exp_q.size() != 0) $display("FAIL bp_drain: %0d outstanding, required 0", exp_q.size()); else n_pass++;
    if (n_issued - n0 != 4) $display("FAIL bp_total_issues: got %0d, required 4", n_issued - n0); else n_pass++;
  endtask

  task automatic test_timeout();
    int t0;
    t0 = to_count;
    dm_silent = 1'b1;
    send(7'h30, DTM_READ, 32'h0, 1'b1, '{data: 32'h0, resp: DTM_ERR});
    for (int i = 0; i < 60 && to_count == t0; i++) @(negedge clk);
    #3;
    n_checks += 3;
    if (to_count != t0 + 1) $display("FAIL to_pulse: got %0d pulses, required 1", to_count - t0); else n_pass++;
    if (to_cyc - hs_cyc != int'(Tmo)) $display("FAIL to_delay: got %0d cycles, required %0d", to_cyc - hs_cyc, Tmo); else n_pass++;
    if (dut.drop_cnt_q !== 2'd1) $display("FAIL to_drop_inc: got %0d, required 1", dut.drop_cnt_q); else n_pass++;
    repeat (4) @(negedge clk);
    bus.dn_resp_i = '{data: 32'hBAD0BAD0, resp: DTM_SUCCESS};
    bus.dn_resp_valid_i = 1'b1;
    @(negedge clk);
    bus.dn_resp_valid_i = 1'b0;
    #3;
    n_checks += 2;
    if (dut.drop_cnt_q !== 2'd0) $display("FAIL to_drop_dec: got %0d, required 0", dut.drop_cnt_q); else n_pass++;
    if (exp_q.size() != 0) $display("FAIL to_err_resp: %0d outstanding, required 0", exp_q.size()); else n_pass++;
    dm_silent = 1'b0;
    dm_lat = 2;
    send(7'h31, DTM_READ, 32'h0, 1'b1, '{data: 32'h0000_3131, resp: DTM_SUCCESS});
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL to_after_drain: %0d outstanding, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_race();
    int t0;
    t0 = to_count;
    dm_lat = Tmo;
    send(7'h32, DTM_READ, 32'h0, 1'b1, '{data: 32'h0000_3232, resp: DTM_SUCCESS});
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    n_checks += 3;
    if (exp_q.size() != 0) $display("FAIL race_drain: %0d outstanding, required 0", exp_q.size()); else n_pass++;
    if (to_count != t0) $display("FAIL race_timeout: got %0d pulses, required 0", to_count - t0); else n_pass++;
    if (dut.drop_cnt_q !== 2'd0) $display("FAIL race_drop: got %0d, required 0", dut.drop_cnt_q); else n_pass++;
  endtask

  task automatic test_clear();
    int n0;
    n0 = n_issued;
    dm_silent = 1'b1;
    send(7'h40, DTM_READ, 32'h0, 1'b0, '0);
    send(7'h41, DTM_READ, 32'h0, 1'b0, '0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #3;
    n_checks += 5;
    if (busy !== 1'b0) $display("FAIL clr_busy: got %b, required 0", busy); else n_pass++;
    if (bus.up_resp_valid_o !== 1'b0) $display("FAIL clr_resp_valid: got %b, required 0", bus.up_resp_valid_o); else n_pass++;
    if (bus.dn_req_valid_o !== 1'b0) $display("FAIL clr_dn_valid: got %b, required 0", bus.dn_req_valid_o); else n_pass++;
    if (bus.up_req_ready_o !== 1'b1) $display("FAIL clr_req_ready: got %b, required 1", bus.up_req_ready_o); else n_pass++;
    if (dut.drop_cnt_q !== 2'd1) $display("FAIL clr_drop: got %0d, required 1", dut.drop_cnt_q); else n_pass++;
    @(negedge clk);
    bus.dn_resp_i = '{data: 32'hBAD1BAD1, resp: DTM_SUCCESS};
    bus.dn_resp_valid_i = 1'b1;
    @(negedge clk);
    bus.dn_resp_valid_i = 1'b0;
    #3;
    n_checks++;
    if (dut.drop_cnt_q !== 2'd0) $display("FAIL clr_late_drop: got %0d, required 0", dut.drop_cnt_q); else n_pass++;
    dm_silent = 1'b0;
    dm_lat = 1;
    send(7'h42, DTM_READ, 32'h0, 1'b1, '{data: 32'h0000_4242, resp: DTM_SUCCESS});
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks += 2;
    if (exp_q.size() != 0) $display("FAIL clr_drain: %0d outstanding, required 0", exp_q.size()); else n_pass++;
    if (n_issued - n0 != 2) $display("FAIL clr_issues: got %0d, required 2", n_issued - n0); else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.dn_req_ready_i = 1'b0;
    send(7'h50, DTM_READ, 32'h0, 1'b0, '0);
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (bus.dn_req_valid_o !== 1'b1) $display("FAIL ar_pre_valid: got %b, required 1", bus.dn_req_valid_o); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.dn_req_valid_o !== 1'b0) $display("FAIL ar_dn_valid: got %b, required 0", bus.dn_req_valid_o); else n_pass++;
    if (bus.up_req_ready_o !== 1'b1) $display("FAIL ar_req_ready: got %b, required 1", bus.up_req_ready_o); else n_pass++;
    if (busy !== 1'b0) $display("FAIL ar_busy: got %b, required 0", busy); else n_pass++;
    if (bus.up_resp_valid_o !== 1'b0) $display("FAIL ar_resp_valid: got %b, required 0", bus.up_resp_valid_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.dn_req_ready_i = 1'b1;
    send(7'h51, DTM_READ, 32'h0, 1'b1, '{data: 32'h0000_5151, resp: DTM_SUCCESS});
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL ar_drain: %0d outstanding, required 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bus.up_req_i        = '0;
    bus.up_req_valid_i  = 1'b0;
    bus.up_resp_ready_i = 1'b1;
    bus.dn_req_ready_i  = 1'b1;
    bus.dn_resp_i       = '0;
    bus.dn_resp_valid_i = 1'b0;
    for (int i = 0; i < 128; i++) dm_mem[i] = {25'h0, 7'(i)} | 32'h0000_3100 & {32{i[5]}};
    dm_mem[7'h11] = 32'h12345678;
    for (int k = 0; k < 4; k++) dm_mem[7'h20 + k] = 32'hA000_0000 + 32'(k);
    dm_mem[7'h31] = 32'h0000_3131;
    dm_mem[7'h32] = 32'h0000_3232;
    dm_mem[7'h42] = 32'h0000_4242;
    dm_mem[7'h51] = 32'h0000_5151;

    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_race();
    test_clear();
    test_async_reset();

    repeat (5) @(negedge clk);
    n_checks += 2;
    if (exp_q.size() != 0) $display("FAIL final_scoreboard: %0d outstanding, required 0", exp_q.size()); else n_pass++;
    if (n_rsp != n_exp) $display("FAIL final_resp_count: got %0d, required %0d", n_rsp, n_exp); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
